// File: rtl/spi_mem_arbiter_if.sv
// Shared memory-request type and the CPU/controller-facing bus of spi_mem_arbiter.
// The arbiter uses the slave view; the CPU core and controller side uses master.
package spi_mem_arbiter_pkg;
   typedef enum logic [1:0] {
      TYPE_IMEM_READ  = 2'd0,
      TYPE_DMEM_READ  = 2'd1,
      TYPE_DMEM_WRITE = 2'd2
   } mem_type_t;
endpackage

interface spi_mem_arbiter_if;
   logic                           if_req_in;
   logic [15:0]                    if_addr_in;
   logic                           if_ack_out;
   logic [15:0]                    if_data_out;
   logic                           dm_req_in;
   logic                           dm_we_in;
   logic [15:0]                    dm_addr_in;
   logic [7:0]                     dm_wdata_in;
   logic                           dm_ack_out;
   logic [7:0]                     dm_rdata_out;
   logic [15:0]                    mem_addr_out;
   logic                           mem_addr_valid_out;
   spi_mem_arbiter_pkg::mem_type_t mem_type_out;
   logic [7:0]                     mem_wdata_out;
   logic [15:0]                    mem_flash_data_in;
   logic                           mem_flash_valid_in;
   logic [7:0]                     mem_psram_data_in;
   logic                           mem_psram_valid_in;
   logic                           mem_busy_in;

   modport slave (
      input  if_req_in, if_addr_in, dm_req_in, dm_we_in, dm_addr_in, dm_wdata_in,
             mem_flash_data_in, mem_flash_valid_in, mem_psram_data_in, mem_psram_valid_in,
             mem_busy_in,
      output if_ack_out, if_data_out, dm_ack_out, dm_rdata_out,
             mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out
   );

   modport master (
      output if_req_in, if_addr_in, dm_req_in, dm_we_in, dm_addr_in, dm_wdata_in,
             mem_flash_data_in, mem_flash_valid_in, mem_psram_data_in, mem_psram_valid_in,
             mem_busy_in,
      input  if_ack_out, if_data_out, dm_ack_out, dm_rdata_out,
             mem_addr_out, mem_addr_valid_out, mem_type_out, mem_wdata_out
   );
endinterface

// File: rtl/spi_mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one spi_flash_controller,
// favouring data but forcing a pending fetch after MAX_DATA_STREAK data grants.
module spi_mem_arbiter
   import spi_mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_DATA_STREAK = 3
) (
   input logic              clk_in,
   input logic              reset_n_in,
   spi_mem_arbiter_if.slave bus
);

   localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;
   typedef enum logic {OWNER_IF, OWNER_DM} owner_t;

   state_t      state, state_nxt;
   owner_t      owner;
   logic [3:0]  streak;
   logic        grant_if, grant_dm;
   logic        capture_if, capture_dm;
   logic [15:0] mem_addr;
   mem_type_t   mem_type;
   logic [7:0]  mem_wdata;
   logic [15:0] if_data;
   logic [7:0]  dm_rdata;

   // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
      if (state == IDLE) begin
         if (bus.dm_req_in && (!bus.if_req_in || streak < STREAK_LIMIT))
            grant_dm = 1'b1;
         else if (bus.if_req_in)
            grant_if = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (grant_if || grant_dm) state_nxt = ISSUE;
         ISSUE:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: if (bus.mem_busy_in) state_nxt = WAIT_DONE;
         WAIT_DONE: if (!bus.mem_busy_in) state_nxt = RESP;
         RESP:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // RESP reloads read data so the result is right even if no valid pulse arrived.
   always_comb begin
      capture_if = (owner == OWNER_IF) &&
                   ((state == WAIT_DONE && bus.mem_flash_valid_in) || state == RESP);
      capture_dm = (owner == OWNER_DM) && (mem_type == TYPE_DMEM_READ) &&
                   ((state == WAIT_DONE && bus.mem_psram_valid_in) || state == RESP);
   end

   // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) state <= IDLE;
      else             state <= state_nxt;
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         owner     <= OWNER_IF;
         streak    <= '0;
         mem_addr  <= '0;
         mem_type  <= TYPE_IMEM_READ;
         mem_wdata <= '0;
         if_data   <= '0;
         dm_rdata  <= '0;
      end else begin
         if (grant_dm) begin
            owner     <= OWNER_DM;
            mem_addr  <= bus.dm_addr_in;
            mem_type  <= bus.dm_we_in ? TYPE_DMEM_WRITE : TYPE_DMEM_READ;
            mem_wdata <= bus.dm_wdata_in;
            // The streak only grows while a fetch is actually being held off.
            if (!bus.if_req_in)
               streak <= '0;
            else if (streak != 4'hF)
               streak <= streak + 4'd1;
         end else if (grant_if) begin
            owner     <= OWNER_IF;
            mem_addr  <= bus.if_addr_in;
            mem_type  <= TYPE_IMEM_READ;
            mem_wdata <= '0;
            streak    <= '0;
         end
         if (capture_if) if_data  <= bus.mem_flash_data_in;
         if (capture_dm) dm_rdata <= bus.mem_psram_data_in;
      end
   end

   assign bus.mem_addr_valid_out = (state == ISSUE);
   assign bus.if_ack_out         = (state == RESP) && (owner == OWNER_IF);
   assign bus.dm_ack_out         = (state == RESP) && (owner == OWNER_DM);
   assign bus.mem_addr_out       = mem_addr;
   assign bus.mem_type_out       = mem_type;
   assign bus.mem_wdata_out      = mem_wdata;
   assign bus.if_data_out        = if_data;
   assign bus.dm_rdata_out       = dm_rdata;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Self-checking bench for spi_mem_arbiter: behavioural controller model, directed
// scenarios plus randomized traffic, checked against a transaction-level reference.
module tb_spi_mem_arbiter;
   import spi_mem_arbiter_pkg::*;

   localparam int MAX_STREAK = 3;

   logic clk_in     = 1'b0;
   logic reset_n_in = 1'b0;
   int   cyc        = 0;
   int   checks     = 0;
   int   errors     = 0;

   spi_mem_arbiter_if bus ();

   spi_mem_arbiter #(.MAX_DATA_STREAK(MAX_STREAK)) dut (
      .clk_in     (clk_in),
      .reset_n_in (reset_n_in),
      .bus        (bus)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Memory contents seen by the controller model and by the reference model.
   logic [15:0] flash_img  [logic [15:0]];
   logic [7:0]  ctrl_psram [logic [15:0]];
   logic [7:0]  ref_psram  [logic [15:0]];

   function automatic logic [15:0] flash_word(input logic [15:0] a);
      return flash_img.exists(a) ? flash_img[a] : ({a[7:0], a[15:8]} ^ 16'h3C96);
   endfunction

   function automatic logic [7:0] psram_default(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h6B;
   endfunction

   function automatic logic [7:0] ref_read(input logic [15:0] a);
      return ref_psram.exists(a) ? ref_psram[a] : psram_default(a);
   endfunction

   // Controller model: busy rises rise_delay cycles after addr_valid, stays high busy_len cycles.
   int rise_delay  = 0;
   int busy_len    = 4;
   bit rand_timing = 1'b0;
   int fall_cyc    = -1;

   initial begin : ctrl_model
      int          phase;
      int          cnt;
      logic [15:0] a;
      mem_type_t   t;
      logic [7:0]  wd;
      bit          early;
      phase = 0;
      cnt   = 0;
      early = 1'b0;
      a     = '0;
      wd    = '0;
      t     = TYPE_IMEM_READ;
      bus.mem_busy_in        = 1'b0;
      bus.mem_flash_valid_in = 1'b0;
      bus.mem_flash_data_in  = '0;
      bus.mem_psram_valid_in = 1'b0;
      bus.mem_psram_data_in  = '0;
      forever begin
         @(negedge clk_in);
         bus.mem_flash_valid_in = 1'b0;
         bus.mem_psram_valid_in = 1'b0;
         if (!reset_n_in) begin
            phase           = 0;
            bus.mem_busy_in = 1'b0;
         end else begin
            if (bus.mem_addr_valid_out) check("single_txn", phase, 0);
            if (phase == 0 && bus.mem_addr_valid_out) begin
               a  = bus.mem_addr_out;
               t  = bus.mem_type_out;
               wd = bus.mem_wdata_out;
               if (rand_timing) begin
                  rise_delay = $urandom_range(0, 3);
                  busy_len   = $urandom_range(2, 8);
               end
               early = 1'($urandom_range(0, 1));
               cnt   = rise_delay;
               phase = 1;
            end else if (phase == 2) begin
               cnt--;
               if ((cnt == 1 && early) || (cnt == 0 && !early)) begin
                  if (t == TYPE_IMEM_READ) begin
                     bus.mem_flash_data_in  = flash_word(a);
                     bus.mem_flash_valid_in = 1'b1;
                  end else if (t == TYPE_DMEM_READ) begin
                     bus.mem_psram_data_in  = ctrl_psram.exists(a) ? ctrl_psram[a] : psram_default(a);
                     bus.mem_psram_valid_in = 1'b1;
                  end
               end
               if (cnt == 0) begin
                  check("mem_addr_stable", bus.mem_addr_out, a);
                  check("mem_type_stable", bus.mem_type_out, t);
                  check("mem_wdata_stable", bus.mem_wdata_out, wd);
                  if (t == TYPE_DMEM_WRITE) ctrl_psram[a] = wd;
                  bus.mem_busy_in = 1'b0;
                  fall_cyc        = cyc;
                  phase           = 0;
               end
            end
            if (phase == 1) begin
               if (cnt == 0) begin
                  bus.mem_busy_in = 1'b1;
                  cnt             = busy_len;
                  phase           = 2;
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   typedef struct {
      mem_type_t   t;
      logic [15:0] a;
      logic [7:0]  wd;
      int          c;
   } issue_t;
   issue_t issued_q [$];

   initial begin : monitor
      issue_t rec;
      forever begin
         @(negedge clk_in);
         if (bus.mem_addr_valid_out) begin
            rec.t  = bus.mem_type_out;
            rec.a  = bus.mem_addr_out;
            rec.wd = bus.mem_wdata_out;
            rec.c  = cyc;
            issued_q.push_back(rec);
         end
         if (bus.if_ack_out || bus.dm_ack_out)
            check("ack_exclusive", {bus.if_ack_out, bus.dm_ack_out}, 2'b01 << bus.if_ack_out);
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference state derived from the arbitration and data rules.
   int          ref_streak   = 0;
   logic [15:0] exp_if_data  = '0;
   logic [7:0]  exp_dm_rdata = '0;
   int          exp_idle_cyc = 0;

   task automatic wait_ack(input int budget, output bit got_if, output bit got_dm, output int ack_cyc);
      bit got;
      got_if  = 1'b0;
      got_dm  = 1'b0;
      ack_cyc = -1;
      got     = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk_in);
         if (bus.if_ack_out || bus.dm_ack_out) begin
            got_if  = bus.if_ack_out;
            got_dm  = bus.dm_ack_out;
            ack_cyc = cyc;
            got     = 1'b1;
         end
      end
      check("ack_within_budget", got, 1);
   endtask

   // Waits for the next completion and checks it against the reference; returns on the ack cycle.
   task automatic complete_one(input bit chk_latency, output bit got_dm);
      bit          exp_dm;
      bit          got_if;
      mem_type_t   exp_t;
      logic [15:0] exp_a;
      int          n0;
      int          ack_cyc;
      exp_dm = bus.dm_req_in && (!bus.if_req_in || ref_streak < MAX_STREAK);
      exp_t  = !exp_dm ? TYPE_IMEM_READ : (bus.dm_we_in ? TYPE_DMEM_WRITE : TYPE_DMEM_READ);
      exp_a  = exp_dm ? bus.dm_addr_in : bus.if_addr_in;
      n0     = issued_q.size();
      fall_cyc = -1;
      wait_ack(300, got_if, got_dm, ack_cyc);
      check("ack_owner_dm", got_dm, exp_dm);
      check("ack_owner_if", got_if, !exp_dm);
      check("addr_valid_pulses", issued_q.size(), n0 + 1);
      if (issued_q.size() == n0 + 1) begin
         check("mem_type", issued_q[n0].t, exp_t);
         check("mem_addr", issued_q[n0].a, exp_a);
         if (exp_t == TYPE_DMEM_WRITE) check("mem_wdata", issued_q[n0].wd, bus.dm_wdata_in);
         if (chk_latency) check("grant_latency", issued_q[n0].c, exp_idle_cyc + 1);
      end
      check("ack_latency", ack_cyc, fall_cyc + 1);
      if (!exp_dm) begin
         exp_if_data = flash_word(exp_a);
         check("if_data", bus.if_data_out, exp_if_data);
         check("dm_rdata_held", bus.dm_rdata_out, exp_dm_rdata);
         ref_streak = 0;
      end else begin
         if (exp_t == TYPE_DMEM_WRITE) ref_psram[exp_a] = bus.dm_wdata_in;
         else                          exp_dm_rdata = ref_read(exp_a);
         check("dm_rdata", bus.dm_rdata_out, exp_dm_rdata);
         check("if_data_held", bus.if_data_out, exp_if_data);
         ref_streak = bus.if_req_in ? ((ref_streak < 15) ? ref_streak + 1 : 15) : 0;
      end
      exp_idle_cyc = ack_cyc + 1;
   endtask

   task automatic new_dm_op(input int max_addr);
      bus.dm_we_in    = 1'($urandom_range(0, 1));
      bus.dm_addr_in  = 16'($urandom_range(0, max_addr));
      bus.dm_wdata_in = 8'($urandom);
   endtask

   initial begin : main
      bit got_dm;
      int dm_before_if;
      bit seen_if;
      int r;
      int n_before;
      int rel_cyc;

      bus.if_req_in   = 1'b0;
      bus.if_addr_in  = '0;
      bus.dm_req_in   = 1'b0;
      bus.dm_we_in    = 1'b0;
      bus.dm_addr_in  = '0;
      bus.dm_wdata_in = '0;
      flash_img[16'h0004] = 16'hA55A;

      // Reset values
      repeat (2) @(negedge clk_in);
      check("rst_if_ack", bus.if_ack_out, 0);
      check("rst_dm_ack", bus.dm_ack_out, 0);
      check("rst_addr_valid", bus.mem_addr_valid_out, 0);
      check("rst_mem_addr", bus.mem_addr_out, 0);
      check("rst_mem_type", bus.mem_type_out, TYPE_IMEM_READ);
      check("rst_if_data", bus.if_data_out, 0);
      check("rst_dm_rdata", bus.dm_rdata_out, 0);
      reset_n_in = 1'b1;
      repeat (2) @(negedge clk_in);

      // Fetch only, long busy
      busy_len = 40;
      bus.if_req_in  = 1'b1;
      bus.if_addr_in = 16'h0004;
      exp_idle_cyc   = cyc;
      complete_one(1'b1, got_dm);
      bus.if_req_in = 1'b0;
      @(negedge clk_in);
      check("if_data_after_ack", bus.if_data_out, 16'hA55A);
      check("if_ack_one_cycle", bus.if_ack_out, 0);

      // Data write then read back
      busy_len = 6;
      bus.dm_req_in   = 1'b1;
      bus.dm_we_in    = 1'b1;
      bus.dm_addr_in  = 16'h0010;
      bus.dm_wdata_in = 8'h55;
      exp_idle_cyc    = cyc;
      complete_one(1'b1, got_dm);
      bus.dm_req_in = 1'b0;
      @(negedge clk_in);
      bus.dm_req_in = 1'b1;
      bus.dm_we_in  = 1'b0;
      exp_idle_cyc  = cyc;
      complete_one(1'b1, got_dm);
      check("dm_read_back", bus.dm_rdata_out, 8'h55);
      bus.dm_req_in = 1'b0;
      @(negedge clk_in);

      // Simultaneous requests: data first, then fetch
      bus.if_req_in  = 1'b1;
      bus.if_addr_in = 16'($urandom);
      bus.dm_req_in  = 1'b1;
      bus.dm_we_in   = 1'b0;
      bus.dm_addr_in = 16'($urandom_range(0, 7));
      exp_idle_cyc   = cyc;
      complete_one(1'b1, got_dm);
      check("simul_first_is_dm", got_dm, 1);
      bus.dm_req_in = 1'b0;
      complete_one(1'b1, got_dm);
      check("simul_second_is_if", got_dm, 0);
      bus.if_req_in = 1'b0;
      @(negedge clk_in);

      // Starvation guard with data re-requesting after every ack
      bus.if_req_in  = 1'b1;
      bus.if_addr_in = 16'($urandom);
      bus.dm_req_in  = 1'b1;
      new_dm_op(7);
      exp_idle_cyc   = cyc;
      dm_before_if   = 0;
      seen_if        = 1'b0;
      for (int k = 0; k < 8; k++) begin
         complete_one(1'b1, got_dm);
         if (got_dm) begin
            if (!seen_if) dm_before_if++;
            new_dm_op(7);
         end else begin
            seen_if        = 1'b1;
            bus.if_addr_in = 16'($urandom);
         end
      end
      check("dm_acks_before_first_if", dm_before_if, 3);
      bus.if_req_in = 1'b0;
      bus.dm_req_in = 1'b0;
      @(negedge clk_in);

      // Busy rise delayed by 5 cycles
      rise_delay     = 5;
      busy_len       = 3;
      bus.if_req_in  = 1'b1;
      bus.if_addr_in = 16'h1234;
      exp_idle_cyc   = cyc;
      complete_one(1'b1, got_dm);
      bus.if_req_in = 1'b0;
      rise_delay    = 0;
      @(negedge clk_in);

      // Randomized mixed traffic
      rand_timing = 1'b1;
      for (int k = 0; k < 24; k++) begin
         if (!bus.if_req_in && !bus.dm_req_in) begin
            repeat ($urandom_range(1, 3)) @(negedge clk_in);
            r = $urandom_range(1, 3);
            if (r[0]) begin
               bus.if_req_in  = 1'b1;
               bus.if_addr_in = 16'($urandom);
            end
            if (r[1]) begin
               bus.dm_req_in = 1'b1;
               new_dm_op(7);
            end
            exp_idle_cyc = cyc;
         end
         complete_one(1'b1, got_dm);
         if (got_dm) begin
            if ($urandom_range(0, 1) == 1) new_dm_op(7);
            else                           bus.dm_req_in = 1'b0;
         end else begin
            if ($urandom_range(0, 1) == 1) bus.if_addr_in = 16'($urandom);
            else                           bus.if_req_in = 1'b0;
         end
      end
      rand_timing   = 1'b0;
      bus.if_req_in = 1'b0;
      bus.dm_req_in = 1'b0;
      repeat (3) @(negedge clk_in);

      // Reset during WAIT_DONE abandons the fetch, then a fresh one restarts
      busy_len       = 30;
      bus.if_req_in  = 1'b1;
      bus.if_addr_in = 16'h0BEE;
      for (int i = 0; i < 50 && !bus.mem_busy_in; i++) @(negedge clk_in);
      check("busy_seen_before_reset", bus.mem_busy_in, 1);
      repeat (4) @(negedge clk_in);
      reset_n_in = 1'b0;
      #1;
      check("midrst_if_ack", bus.if_ack_out, 0);
      check("midrst_addr_valid", bus.mem_addr_valid_out, 0);
      check("midrst_mem_addr", bus.mem_addr_out, 0);
      check("midrst_mem_type", bus.mem_type_out, TYPE_IMEM_READ);
      check("midrst_mem_wdata", bus.mem_wdata_out, 0);
      check("midrst_if_data", bus.if_data_out, 0);
      check("midrst_dm_rdata", bus.dm_rdata_out, 0);
      repeat (2) @(negedge clk_in);
      ref_streak     = 0;
      exp_if_data    = '0;
      exp_dm_rdata   = '0;
      busy_len       = 4;
      bus.if_addr_in = 16'h0C40;
      n_before       = issued_q.size();
      reset_n_in     = 1'b1;
      rel_cyc        = cyc;
      complete_one(1'b0, got_dm);
      if (issued_q.size() > n_before)
         check("restart_within_2", (issued_q[n_before].c - rel_cyc) <= 2, 1);
      bus.if_req_in = 1'b0;
      repeat (3) @(negedge clk_in);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
- Shares the single spi_flash_controller between the CPU instruction-fetch port (flash, 16-bit reads) and the data port (PSRAM, 8-bit reads and writes).
- Latches requests and arbitrates them, with data priority bounded by a starvation guard.
- Sequences the controller's addr_valid/busy protocol and returns read data to the owning requester with a one-cycle ack.
- Sits between the CPU core and spi_flash_controller.

Parameters:
MAX_DATA_STREAK, 3, consecutive data grants allowed while a fetch is pending before the fetch is forced (legal range 1..15).

Ports:
clk_in  input  1  system clock
reset_n_in  input  1  reset, asynchronous, active-low
if_req_in  input  1  fetch request; addr held stable until if_ack_out
if_addr_in  input  16  fetch address
if_ack_out  output  1  one-cycle fetch completion pulse
if_data_out  output  16  fetch data; valid when if_ack_out=1, held afterwards
dm_req_in  input  1  data request; addr/we/wdata held stable until dm_ack_out
dm_we_in  input  1  1=write, 0=read
dm_addr_in  input  16  data address
dm_wdata_in  input  8  write data
dm_ack_out  output  1  one-cycle data completion pulse
dm_rdata_out  output  8  read data; valid when dm_ack_out=1 after a read, held afterwards
mem_addr_out  output  16  to controller addr_in
mem_addr_valid_out  output  1  to controller addr_valid_in, one-cycle pulse
mem_type_out  output  mem_type_t  to controller mem_type_in
mem_wdata_out  output  8  to controller psram_data_in
mem_flash_data_in  input  16  from controller flash_data_out
mem_flash_valid_in  input  1  from controller flash_data_valid_out
mem_psram_data_in  input  8  from controller psram_data_out
mem_psram_valid_in  input  1  from controller psram_data_valid_out
mem_busy_in  input  1  from controller busy_out

Behaviour:
- Clocking and reset: all state is on posedge clk_in. reset_n_in low asynchronously clears every output and register to 0, sets state to IDLE and sets mem_type_out to TYPE_IMEM_READ.
- Reset mid-transaction abandons the transaction with no ack. The controller is reset separately.
- State IDLE:
  - Samples if_req_in and dm_req_in.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high: grant data if streak<MAX_DATA_STREAK, else grant fetch.
  - On a grant, register mem_addr_out, mem_type_out and mem_wdata_out, plus owner=IF/DM, then go to ISSUE.
  - mem_type_out per owner: IF gives TYPE_IMEM_READ; DM with we=0 gives TYPE_DMEM_READ; DM with we=1 gives TYPE_DMEM_WRITE.
- Streak counter (4-bit):
  - On a DM grant while if_req_in is high: increment, saturating.
  - On an IF grant, or a DM grant with if_req_in low: clear.
- State ISSUE: mem_addr_valid_out=1 for exactly this cycle, then go to WAIT_BUSY.
- State WAIT_BUSY: wait for mem_busy_in=1, then go to WAIT_DONE. This tolerates rise latency of any length.
- State WAIT_DONE:
  - Capture mem_flash_data_in into if_data_out on mem_flash_valid_in when owner=IF.
  - Capture mem_psram_data_in into dm_rdata_out on mem_psram_valid_in when owner=DM and type is read.
  - On mem_busy_in=0, go to RESP.
  - If a valid pulse coincides with busy falling, the data is still captured.
- State RESP:
  - The owner's ack is 1 for one cycle; the other ack stays 0.
  - Read data is also loaded from the controller outputs in this cycle, so data is correct even if no valid pulse was seen.
  - Next state is IDLE.
- Outputs during a transaction: mem_addr_out, mem_type_out and mem_wdata_out stay constant from ISSUE through RESP.
- Latency: request seen in IDLE at cycle 0 gives the addr_valid pulse at cycle 1. Busy falling at cycle N gives ack at cycle N+1. After RESP, one IDLE cycle precedes the next grant.
- Handshake rules:
  - A requester changes req/addr only at the edge where it sees ack.
  - A req still high in the IDLE cycle after RESP is a new request.
  - A write ack leaves dm_rdata_out unchanged.
- Requester behaviour during a transaction: the non-owning requester stays pending, with no ack, until it is granted. Req deassertion before ack is illegal and unchecked.
- Never: two concurrent controller transactions, or both acks high at once.

Test Plan:
- Fetch only: if_addr=0x0004, controller model busy 40 cycles, flash data 0xA55A -> one mem_addr_valid pulse with TYPE_IMEM_READ and addr 0x0004; if_ack one cycle after busy falls; if_data_out=0xA55A.
- Data write then read: dm_we=1, addr 0x0010, wdata 0x55 -> TYPE_DMEM_WRITE, mem_wdata_out=0x55, dm_ack, dm_rdata unchanged. Then read of 0x0010 -> TYPE_DMEM_READ, dm_rdata_out=0x55.
- Simultaneous requests in one IDLE cycle: data is granted first, then the fetch; exactly one addr_valid pulse per transaction; both acks are never high together.
- Starvation: if_req held, dm_req re-asserted immediately after every ack, MAX_DATA_STREAK=3 -> grant order DM, DM, DM, IF, DM…; if_ack arrives after the 3rd dm_ack.
- Busy rise delayed by 5 cycles after addr_valid -> arbiter stays in WAIT_BUSY with no premature ack; completes normally.
- reset_n_in pulled low during WAIT_DONE -> all outputs 0 immediately with no ack. After release with if_req high, a fresh transaction is issued within 2 cycles.
